decode_rename_queue: RTL
========================

Name: decode_rename_queue

Overview:
- Small group FIFO between the decode stage and the rename stage.
- Each entry holds one decode group of DECODE_WIDTH micro-ops plus per-lane valid bits. This absorbs rename back-pressure so decode keeps running for DEPTH groups.
- Registers the decode-detected redirect (flush, recovered PC, branch history, RAS checkpoint) for one cycle before it goes to fetch.
- A backend recovery flush wipes the queue and cancels any pending decode redirect.

Parameters:
DECODE_WIDTH, 2, micro-op lanes per group
OP_WIDTH, 64, bits of packed rename-stage payload per lane
DEPTH, 4, group entries; power of two, >=2
ADDR_WIDTH, 32, PC width
GH_WIDTH, 10, global branch history width
RAS_CP_WIDTH, 16, RAS checkpoint width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enq_valid  in  1  decode presents a group this cycle
enq_lane_valid  in  DECODE_WIDTH  per-lane valid within group
enq_op  in  DECODE_WIDTH*OP_WIDTH  lane payloads, lane 0 in LSBs
enq_ready  out  1  queue can accept a group (not full)
dec_flush  in  1  decode-detected redirect; qualified by enq_valid&&enq_ready
dec_recovered_pc  in  ADDR_WIDTH  redirect target
dec_recovered_gh  in  GH_WIDTH  repaired branch history
dec_recovered_ras  in  RAS_CP_WIDTH  RAS checkpoint
deq_valid  out  1  head group valid
deq_lane_valid  out  DECODE_WIDTH  head per-lane valid
deq_op  out  DECODE_WIDTH*OP_WIDTH  head payloads
deq_ready  in  1  rename accepts head
backend_flush  in  1  backend recovery; squashes everything
redirect_valid  out  1  registered decode redirect to fetch
redirect_pc  out  ADDR_WIDTH  registered target
redirect_gh  out  GH_WIDTH  registered history
redirect_ras  out  RAS_CP_WIDTH  registered RAS checkpoint
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH

Behaviour:
- Reset: all outputs 0 except enq_ready=1. Pointers and count cleared. Storage contents are don't-care.
- Reset dominates backend_flush, which dominates every other input.
- Enqueue fires when enq_valid && enq_ready. The entry is written at the tail and is visible at deq_* no earlier than the next cycle. There is no combinational enq->deq bypass, so latency is 1 cycle.
- Dequeue fires when deq_valid && deq_ready. The head advances at the clock edge.
- deq_* outputs are driven from the head entry; when empty they must be 0.
- Groups with enq_lane_valid==0 and enq_valid=1 are still enqueued; the bench checks pass-through only.
- enq_ready = (count != DEPTH). It is registered-count based and does not depend on deq_ready in the same cycle: no enqueue when full, even with a simultaneous dequeue.
- Simultaneous enq and deq with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by count.
- Decode redirect:
  - When dec_flush arrives with an accepted enqueue, the carrying group is enqueued normally (the redirecting op is older and valid).
  - Next cycle redirect_valid=1 for exactly one cycle, with pc/gh/ras captured from that cycle.
  - dec_flush without an accepted enqueue is ignored.
- backend_flush=1:
  - At the edge, count, head and tail go to 0.
  - Any enqueue or dequeue in the same cycle is discarded.
  - redirect_valid next cycle = 0, even if dec_flush was accepted in the same cycle.
  - A redirect already being presented (redirect_valid=1) this cycle is not retracted; fetch prioritises the backend.
- redirect_pc/gh/ras hold their last captured value when redirect_valid=0.
- No assertions are fired on deq_ready while empty; it is ignored.

Decomposition:
- Shared package: DECODE_WIDTH, ADDR_WIDTH, GH_WIDTH, RAS_CP_WIDTH, and typedefs for the lane payload and the redirect record {pc, gh, ras}.
- Queue pointers/count go in one natural sub-module, group_fifo_ctrl (head, tail, count, full/empty, wrap).
- The redirect register stays in the top level.

Test Plan:
- Reset then idle -> enq_ready=1, deq_valid=0, redirect_valid=0, count=0.
- Fill: 4 enqueues with deq_ready=0, groups tagged 0xA0..0xA3 -> count=4, enq_ready=0. A fifth enq_valid is not accepted. Draining yields 0xA0..0xA3 in order, lane_valid preserved.
- Streaming with wrap: enq and deq every cycle for 10 groups at count=2 -> count stays 2, output order exact, pointers wrap twice.
- Decode redirect: group with dec_flush=1, pc=0x0000_1234, gh=0x2AB, ras=0xBEEF accepted at cycle T -> redirect_valid=1 only at T+1 with those values; the group is still delivered to rename.
- Backend flush at count=3, with a simultaneous enq carrying dec_flush -> next cycle count=0, deq_valid=0, redirect_valid=0, enq_ready=1.
- Full plus simultaneous deq: count=4, deq_ready=1, enq_valid=1 -> enq not accepted, count=3; next cycle enq accepted.

Source files
------------

// File: rtl/decode_rename_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_rename_queue_pkg
// Description : Default widths and shared types for the decode->rename queue.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_rename_queue_pkg;

  localparam int c_DECODE_WIDTH = 2;
  localparam int c_OP_WIDTH     = 64;
  localparam int c_DEPTH        = 4;
  localparam int c_ADDR_WIDTH   = 32;
  localparam int c_GH_WIDTH     = 10;
  localparam int c_RAS_CP_WIDTH = 16;

  typedef logic [c_OP_WIDTH-1:0] laneOp_t;

  typedef struct packed {
    logic [c_ADDR_WIDTH-1:0]   pc;
    logic [c_GH_WIDTH-1:0]     gh;
    logic [c_RAS_CP_WIDTH-1:0] ras;
  } redirect_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_rename_queue_group_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : group_fifo_ctrl
// Description : Head/tail pointers and occupancy count for the group queue.
// Revision    : 1.0 - initial release
// ============================================================================
module group_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_enqValid,
  input  logic                       i_deqReady,
  output logic                       o_enqReady,
  output logic                       o_deqValid,
  output logic                       o_enqFire,
  output logic [$clog2(DEPTH)-1:0]   o_headPtr,
  output logic [$clog2(DEPTH)-1:0]   o_tailPtr,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_notFull;
  logic             w_notEmpty;
  logic             w_enqFire;
  logic             w_deqFire;

  // Full/empty come from the registered count only, so a dequeue never frees
  // a slot for an enqueue in the same cycle.
  assign w_notFull  = (r_count != c_CNT_MAX);
  assign w_notEmpty = (r_count != '0);
  assign w_enqFire  = i_enqValid && w_notFull;
  assign w_deqFire  = i_deqReady && w_notEmpty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enqFire) r_tail <= r_tail + c_PTR_ONE;
      if (w_deqFire) r_head <= r_head + c_PTR_ONE;
      case ({w_enqFire, w_deqFire})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_enqReady = w_notFull;
  assign o_deqValid = w_notEmpty;
  assign o_enqFire  = w_enqFire && !i_flush;
  assign o_headPtr  = r_head;
  assign o_tailPtr  = r_tail;
  assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/decode_rename_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_rename_queue
// Description : Group FIFO between decode and rename with registered redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_rename_queue
  import decode_rename_queue_pkg::*;
#(
  parameter int DECODE_WIDTH = c_DECODE_WIDTH,
  parameter int OP_WIDTH     = c_OP_WIDTH,
  parameter int DEPTH        = c_DEPTH,
  parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int GH_WIDTH     = c_GH_WIDTH,
  parameter int RAS_CP_WIDTH = c_RAS_CP_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enq_valid,
  input  logic [DECODE_WIDTH-1:0]          enq_lane_valid,
  input  logic [DECODE_WIDTH*OP_WIDTH-1:0] enq_op,
  output logic                             enq_ready,
  input  logic                             dec_flush,
  input  logic [ADDR_WIDTH-1:0]            dec_recovered_pc,
  input  logic [GH_WIDTH-1:0]              dec_recovered_gh,
  input  logic [RAS_CP_WIDTH-1:0]          dec_recovered_ras,
  output logic                             deq_valid,
  output logic [DECODE_WIDTH-1:0]          deq_lane_valid,
  output logic [DECODE_WIDTH*OP_WIDTH-1:0] deq_op,
  input  logic                             deq_ready,
  input  logic                             backend_flush,
  output logic                             redirect_valid,
  output logic [ADDR_WIDTH-1:0]            redirect_pc,
  output logic [GH_WIDTH-1:0]              redirect_gh,
  output logic [RAS_CP_WIDTH-1:0]          redirect_ras,
  output logic [cntWidth(DEPTH)-1:0]       count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int PAY_W   = DECODE_WIDTH * OP_WIDTH;
  localparam int ENTRY_W = DECODE_WIDTH + PAY_W;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   pc;
    logic [GH_WIDTH-1:0]     gh;
    logic [RAS_CP_WIDTH-1:0] ras;
  } redirectRec_t;

  logic [ENTRY_W-1:0] r_groupMem [DEPTH];
  logic [ENTRY_W-1:0] w_headEntry;
  logic [PTR_W-1:0]   w_headPtr;
  logic [PTR_W-1:0]   w_tailPtr;
  logic               w_enqFire;
  logic               w_deqValid;
  logic               r_redirectValid;
  redirectRec_t       r_redirect;

  group_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (backend_flush),
    .i_enqValid (enq_valid),
    .i_deqReady (deq_ready),
    .o_enqReady (enq_ready),
    .o_deqValid (w_deqValid),
    .o_enqFire  (w_enqFire),
    .o_headPtr  (w_headPtr),
    .o_tailPtr  (w_tailPtr),
    .o_count    (count)
  );

  // Storage carries no reset; stale entries are masked by the empty check.
  always_ff @(posedge clk) begin
    if (w_enqFire) r_groupMem[w_tailPtr] <= {enq_lane_valid, enq_op};
  end

  assign w_headEntry    = r_groupMem[w_headPtr];
  assign deq_valid      = w_deqValid;
  assign deq_lane_valid = w_deqValid ? w_headEntry[ENTRY_W-1:PAY_W] : '0;
  assign deq_op         = w_deqValid ? w_headEntry[PAY_W-1:0] : '0;

  // A backend flush cancels a redirect being captured this cycle but keeps
  // the last captured record on the payload outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirectValid <= 1'b0;
      r_redirect      <= '0;
    end else if (backend_flush) begin
      r_redirectValid <= 1'b0;
    end else begin
      r_redirectValid <= dec_flush && w_enqFire;
      if (dec_flush && w_enqFire) begin
        r_redirect.pc  <= dec_recovered_pc;
        r_redirect.gh  <= dec_recovered_gh;
        r_redirect.ras <= dec_recovered_ras;
      end
    end
  end

  assign redirect_valid = r_redirectValid;
  assign redirect_pc    = r_redirect.pc;
  assign redirect_gh    = r_redirect.gh;
  assign redirect_ras   = r_redirect.ras;

endmodule
`default_nettype wire
